// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer (IDLE/RUN/DONE) for the 9-bit-instruction core.
// Optional macro FETCH_CYCLE_CNT_EN adds a saturating 16-bit CycleCnt output.
module fetch_unit #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFS_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic             ZERO,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFS_W-1:0] Offset,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Valid,
  output logic             Done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]      CycleCnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ofs_ext;

  assign ofs_ext = PC_W'($signed(Offset));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Stall masks every other control for the cycle.
        if (!Stall) begin
          if (Halt) begin
            state_d = ST_DONE;
          end else if (jump_en) begin
            pc_d = Target;
          end else if (branch_en && ZERO) begin
            pc_d = pc_q + ofs_ext;
          end else if (pc_q == '1) begin
            state_d = ST_DONE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers, so no input reaches them combinationally.
  assign ProgCtr = pc_q;
  assign Valid   = (state_q == ST_RUN);
  assign Done    = (state_q == ST_DONE);

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (state_q != ST_RUN && Start) begin
      cnt_q <= '0;
    end else if (state_q == ST_RUN && cnt_q != '1) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign CycleCnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a cycle-level reference model.
// Define FETCH_CYCLE_CNT_EN here too to exercise CycleCnt.
module tb_fetch_unit;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned OFS_W = 8;
  localparam int unsigned PC_MOD = 1 << PC_W;

  logic             Clk = 1'b0;
  logic             Reset, Start, Halt, Stall, jump_en, branch_en, ZERO;
  logic [PC_W-1:0]  StartAddr, Target;
  logic [OFS_W-1:0] Offset;
  logic [PC_W-1:0]  ProgCtr;
  logic             Valid, Done;
`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0]      CycleCnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = running, 2 = finished
  int          m_state = 0;
  int unsigned m_pc    = 0;
  int unsigned m_cnt   = 0;

  fetch_unit #(.PC_W(PC_W), .OFS_W(OFS_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Halt(Halt), .Stall(Stall), .jump_en(jump_en), .branch_en(branch_en),
    .ZERO(ZERO), .Target(Target), .Offset(Offset),
    .ProgCtr(ProgCtr), .Valid(Valid), .Done(Done)
`ifdef FETCH_CYCLE_CNT_EN
    , .CycleCnt(CycleCnt)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Reset = 0; Start = 0; StartAddr = '0; Halt = 0; Stall = 0;
    jump_en = 0; branch_en = 0; ZERO = 0; Target = '0; Offset = '0;
  endtask

  // Advance the model by one edge from the inputs currently applied.
  task automatic model_step();
    int ofs;
    ofs = int'(Offset);
    if (ofs >= 128) ofs = ofs - 256;
    if (Reset) begin
      m_state = 0; m_pc = 0; m_cnt = 0;
    end else if (m_state == 1) begin
      if (m_cnt < 65535) m_cnt++;
      if (Stall) begin
      end else if (Halt) m_state = 2;
      else if (jump_en) m_pc = int'(Target);
      else if (branch_en && ZERO) m_pc = unsigned'((int'(m_pc) + ofs + int'(PC_MOD)) % int'(PC_MOD));
      else if (m_pc == PC_MOD - 1) m_state = 2;
      else m_pc = m_pc + 1;
    end else if (Start) begin
      m_pc = int'(StartAddr); m_state = 1; m_cnt = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check("pc", 32'(ProgCtr), 32'(m_pc));
    check("valid", 32'(Valid), 32'(m_state == 1));
    check("done", 32'(Done), 32'(m_state == 2));
`ifdef FETCH_CYCLE_CNT_EN
    check("cnt", 32'(CycleCnt), 32'(m_cnt));
`endif
  endtask

  task automatic jump_to(input logic [PC_W-1:0] t);
    clear_inputs(); jump_en = 1; Target = t; tick(); clear_inputs();
  endtask

  initial begin
    clear_inputs();
    Reset = 1;
    tick(); tick();
    check("rst_pc", 32'(ProgCtr), 32'h0);
    check("rst_valid", 32'(Valid), 32'h0);
    clear_inputs();

    // Controls in IDLE are ignored
    jump_en = 1; Target = 10'h005; Halt = 1; branch_en = 1; ZERO = 1; Offset = 8'h10;
    tick();
    check("idle_hold", 32'(ProgCtr), 32'h0);
    clear_inputs();

    Start = 1; StartAddr = '0; tick(); clear_inputs();
    check("start_pc", 32'(ProgCtr), 32'h0);
    check("start_valid", 32'(Valid), 32'h1);
    repeat (3) tick();
    check("seq_pc", 32'(ProgCtr), 32'h3);
    repeat (2) tick();

    branch_en = 1; ZERO = 1; Offset = 8'hFD; tick();
    check("br_back", 32'(ProgCtr), 32'h2);
    jump_to(10'h005);
    branch_en = 1; ZERO = 0; Offset = 8'hFD; tick();
    check("br_not_taken", 32'(ProgCtr), 32'h6);
    jump_to(10'h001);
    branch_en = 1; ZERO = 1; Offset = 8'hFC; tick();
    check("br_wrap", 32'(ProgCtr), 32'h3FD);
    jump_to(10'h007);
    jump_en = 1; branch_en = 1; ZERO = 1; Target = 10'h040; Offset = 8'h03; tick();
    check("jump_prio", 32'(ProgCtr), 32'h040);
    jump_to(10'h009);

    Stall = 1; Halt = 1; tick();
    check("stall_pc", 32'(ProgCtr), 32'h9);
    check("stall_valid", 32'(Valid), 32'h1);
    Stall = 0; tick(); clear_inputs();
    check("halt_done", 32'(Done), 32'h1);
    check("halt_pc", 32'(ProgCtr), 32'h9);
    tick();
    Start = 1; StartAddr = 10'h010; tick(); clear_inputs();
    check("restart_pc", 32'(ProgCtr), 32'h010);
    check("restart_done", 32'(Done), 32'h0);

    // Start while running is ignored
    Start = 1; StartAddr = 10'h200; tick(); clear_inputs();
    check("run_start_ign", 32'(ProgCtr), 32'h011);

    Halt = 1; tick(); clear_inputs();
    Start = 1; StartAddr = 10'h3FE; tick(); clear_inputs();
    tick();
    check("eom_last", 32'(ProgCtr), 32'h3FF);
    tick();
    check("eom_done", 32'(Done), 32'h1);
    tick();
    check("eom_hold", 32'(ProgCtr), 32'h3FF);

    Start = 1; StartAddr = '0; tick(); clear_inputs();
    jump_to(10'h123);
    Reset = 1; tick(); clear_inputs();
    check("midrun_rst_pc", 32'(ProgCtr), 32'h0);
    check("midrun_rst_valid", 32'(Valid), 32'h0);

`ifdef FETCH_CYCLE_CNT_EN
    Start = 1; StartAddr = '0; tick(); clear_inputs();
    repeat (4) tick();
    Stall = 1; repeat (2) tick();
    Stall = 0; Halt = 1; tick(); clear_inputs();
    check("cnt_total", 32'(CycleCnt), 32'd7);
    tick();
    check("cnt_frozen", 32'(CycleCnt), 32'd7);
    Start = 1; tick(); clear_inputs();
    check("cnt_cleared", 32'(CycleCnt), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      Start     = ($urandom_range(0, 7) == 0);
      StartAddr = ($urandom_range(0, 3) == 0) ? PC_W'($urandom_range(1008, 1023)) : PC_W'($urandom);
      Halt      = ($urandom_range(0, 19) == 0);
      Stall     = ($urandom_range(0, 4) == 0);
      jump_en   = ($urandom_range(0, 7) == 0);
      branch_en = ($urandom_range(0, 3) == 0);
      ZERO      = 1'($urandom);
      Target    = ($urandom_range(0, 3) == 0) ? PC_W'($urandom_range(1016, 1023)) : PC_W'($urandom);
      Offset    = OFS_W'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
